// File: rtl/demux_captura_pkg.sv
// Shared constants and FSM encoding for the sensor-bus frame de-serialiser.
package demux_captura_pkg;

  localparam int unsigned WIDTH  = 11;
  localparam int unsigned SLOTS  = 4;
  localparam int unsigned SLOT_W = 2;

  localparam logic [SLOT_W-1:0] SLOT_T_ALTA  = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_T_MEDIA = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_HUMO    = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT_ELEC    = 2'd3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_captura_slot_tracker.sv
// Frame alignment tracker: slot counter, sync checking and HUNT/LOCKED FSM.
// Produces combinational strobes telling the datapath what to do this sample.
module demux_captura_slot_tracker
  import demux_captura_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              muestra,
  output logic              locked,
  output logic              cap_en_c,
  output logic [SLOT_W-1:0] cap_slot_c,
  output logic              commit_c,
  output logic              err_c,
  output logic              unlock_c
);

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] slot, slot_nxt;

  // State and slot counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      slot  <= SLOT_T_ALTA;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Next-state and strobe decode; nothing moves on unsampled cycles.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    cap_en_c   = 1'b0;
    cap_slot_c = SLOT_T_ALTA;
    commit_c   = 1'b0;
    err_c      = 1'b0;
    unlock_c   = 1'b0;
    if (muestra) begin
      case (state)
        HUNT: begin
          if (sync) begin
            cap_en_c  = 1'b1;
            slot_nxt  = SLOT_T_MEDIA;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == SLOT_T_ALTA) begin
            if (sync) begin
              cap_en_c = 1'b1;
              slot_nxt = SLOT_T_MEDIA;
            end else begin
              err_c     = 1'b1;
              unlock_c  = 1'b1;
              state_nxt = HUNT;
            end
          end else if (sync) begin
            // Early sync: restart the frame on this word.
            err_c    = 1'b1;
            cap_en_c = 1'b1;
            slot_nxt = SLOT_T_MEDIA;
          end else if (slot == SLOT_ELEC) begin
            commit_c = 1'b1;
            slot_nxt = SLOT_T_ALTA;
          end else begin
            cap_en_c   = 1'b1;
            cap_slot_c = slot;
            slot_nxt   = slot + 2'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/demux_captura.sv
// Receive-side demultiplexer for the four-slot sensor bus: captures slots
// into shadow registers and publishes a complete frame atomically.
module demux_captura
  import demux_captura_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] y_in,
  input  logic             sync,
  input  logic             muestra,
  input  logic             err_clr,
  output logic [WIDTH-1:0] T_alta,
  output logic [WIDTH-1:0] T_media,
  output logic [WIDTH-1:0] Humo,
  output logic [WIDTH-1:0] Elec,
  output logic             frame_done,
  output logic             valid,
  output logic             locked,
  output logic             sync_err
);

  logic              cap_en_c;
  logic [SLOT_W-1:0] cap_slot_c;
  logic              commit_c;
  logic              err_c;
  logic              unlock_c;
  logic [WIDTH-1:0]  shadow_0, shadow_1, shadow_2;

  demux_captura_slot_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .muestra    (muestra),
    .locked     (locked),
    .cap_en_c   (cap_en_c),
    .cap_slot_c (cap_slot_c),
    .commit_c   (commit_c),
    .err_c      (err_c),
    .unlock_c   (unlock_c)
  );

  // Shadow capture of slots 0..2; slot 3 goes straight to the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_0 <= '0;
      shadow_1 <= '0;
      shadow_2 <= '0;
    end else if (cap_en_c) begin
      case (cap_slot_c)
        SLOT_T_ALTA:  shadow_0 <= y_in;
        SLOT_T_MEDIA: shadow_1 <= y_in;
        SLOT_HUMO:    shadow_2 <= y_in;
        default:      ;
      endcase
    end
  end

  // Atomic publish of the whole frame on the slot-3 sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      T_alta     <= '0;
      T_media    <= '0;
      Humo       <= '0;
      Elec       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit_c;
      if (commit_c) begin
        T_alta  <= shadow_0;
        T_media <= shadow_1;
        Humo    <= shadow_2;
        Elec    <= y_in;
      end
    end
  end

  // Status flags: valid tracks a good frame since lock; sync_err is sticky, set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (commit_c)      valid <= 1'b1;
      else if (unlock_c) valid <= 1'b0;
      if (err_c)         sync_err <= 1'b1;
      else if (err_clr)  sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux_captura.sv
// Directed self-checking bench for demux_captura.
module tb_demux_captura;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] y_in;
  logic        sync;
  logic        muestra;
  logic        err_clr;
  logic [10:0] T_alta, T_media, Humo, Elec;
  logic        frame_done, valid, locked, sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  demux_captura dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .sync       (sync),
    .muestra    (muestra),
    .err_clr    (err_clr),
    .T_alta     (T_alta),
    .T_media    (T_media),
    .Humo       (Humo),
    .Elec       (Elec),
    .frame_done (frame_done),
    .valid      (valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the edge.
  task automatic step(input logic [10:0] w, input logic s, input logic m, input logic e);
    y_in = w; sync = s; muestra = m; err_clr = e;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; y_in = '0; sync = 1'b0; muestra = 1'b0; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== 44'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", T_alta, T_media, Humo, Elec);
    end
    n_tests++;
    if ({frame_done, valid, locked, sync_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got fd/v/l/e=%b want 0000", {frame_done, valid, locked, sync_err});
    end
  endtask

  task automatic test_basic_frame();
    step(11'h101, 1, 1, 0);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_sync: got %b want 1", locked); end
    step(11'h202, 0, 1, 0);
    step(11'h303, 0, 1, 0);
    n_tests++;
    if (frame_done !== 1'b0 || T_alta !== 11'h000) begin
      n_fail++; $display("FAIL no_midframe_publish: got fd=%b T_alta=%h want 0/000", frame_done, T_alta);
    end
    step(11'h404, 0, 1, 0);
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h101, 11'h202, 11'h303, 11'h404}) begin
      n_fail++; $display("FAIL frame1_data: got %h/%h/%h/%h want 101/202/303/404", T_alta, T_media, Humo, Elec);
    end
    n_tests++;
    if (frame_done !== 1'b1 || valid !== 1'b1) begin
      n_fail++; $display("FAIL frame1_flags: got fd=%b v=%b want 1/1", frame_done, valid);
    end
  endtask

  task automatic test_back_to_back();
    step(11'h101, 1, 1, 0);
    n_tests++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL fd_one_cycle: got %b want 0", frame_done); end
    step(11'h202, 0, 1, 0);
    step(11'h303, 0, 1, 0);
    step(11'h404, 0, 1, 0);
    n_tests++;
    if (frame_done !== 1'b1 || Elec !== 11'h404 || T_alta !== 11'h101) begin
      n_fail++; $display("FAIL frame2: got fd=%b T_alta=%h Elec=%h want 1/101/404", frame_done, T_alta, Elec);
    end
  endtask

  task automatic test_ignore_prefix();
    apply_reset();
    for (int i = 0; i < 3; i++) step(11'h7FF, 0, 1, 0);
    n_tests++;
    if (locked !== 1'b0 || T_alta !== 11'h000 || Elec !== 11'h000) begin
      n_fail++; $display("FAIL prefix_ignored: got l=%b T_alta=%h Elec=%h want 0/000/000", locked, T_alta, Elec);
    end
    step(11'h111, 1, 1, 0);
    step(11'h222, 0, 1, 0);
    step(11'h333, 0, 1, 0);
    step(11'h444, 0, 1, 0);
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h111, 11'h222, 11'h333, 11'h444} || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL after_prefix: got %h/%h/%h/%h fd=%b want 111/222/333/444 fd=1", T_alta, T_media, Humo, Elec, frame_done);
    end
  endtask

  task automatic test_early_sync();
    step(11'h011, 1, 1, 0);
    step(11'h022, 0, 1, 0);
    step(11'h033, 1, 1, 0);
    n_tests++;
    if (sync_err !== 1'b1 || frame_done !== 1'b0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL early_sync_flags: got e=%b fd=%b l=%b want 1/0/1", sync_err, frame_done, locked);
    end
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h111, 11'h222, 11'h333, 11'h444}) begin
      n_fail++; $display("FAIL early_sync_hold: got %h/%h/%h/%h want 111/222/333/444", T_alta, T_media, Humo, Elec);
    end
    step(11'h044, 0, 1, 0);
    step(11'h055, 0, 1, 0);
    step(11'h066, 0, 1, 0);
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h033, 11'h044, 11'h055, 11'h066} || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL resync_frame: got %h/%h/%h/%h fd=%b want 033/044/055/066 fd=1", T_alta, T_media, Humo, Elec, frame_done);
    end
  endtask

  task automatic test_sync_loss();
    step(11'h000, 0, 0, 1);
    n_tests++;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL err_clr_alone: got %b want 0", sync_err); end
    step(11'h777, 0, 1, 0);
    n_tests++;
    if (sync_err !== 1'b1 || valid !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL sync_loss: got e=%b v=%b l=%b want 1/0/0", sync_err, valid, locked);
    end
    n_tests++;
    if (T_alta !== 11'h033) begin n_fail++; $display("FAIL loss_hold: got T_alta=%h want 033", T_alta); end
    step(11'h000, 0, 1, 1);
    n_tests++;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL err_clr_after_loss: got %b want 0", sync_err); end
    step(11'h0A1, 1, 1, 0);
    step(11'h0A2, 0, 1, 0);
    step(11'h0A3, 0, 1, 0);
    step(11'h0A4, 0, 1, 0);
    step(11'h0A5, 0, 1, 1);
    n_tests++;
    if (sync_err !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL set_beats_clr: got e=%b l=%b want 1/0", sync_err, locked);
    end
  endtask

  task automatic test_muestra_stall();
    int fd_count;
    apply_reset();
    fd_count = 0;
    step(11'h1A1, 1, 1, 0); fd_count += int'(frame_done);
    step(11'h3FF, 1, 0, 0); fd_count += int'(frame_done);
    step(11'h1A2, 0, 1, 0); fd_count += int'(frame_done);
    step(11'h3FF, 1, 0, 0); fd_count += int'(frame_done);
    step(11'h1A3, 0, 1, 0); fd_count += int'(frame_done);
    step(11'h3FF, 0, 0, 0); fd_count += int'(frame_done);
    n_tests++;
    if (sync_err !== 1'b0 || T_alta !== 11'h000) begin
      n_fail++; $display("FAIL stall_hold: got e=%b T_alta=%h want 0/000", sync_err, T_alta);
    end
    step(11'h1A4, 0, 1, 0); fd_count += int'(frame_done);
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h1A1, 11'h1A2, 11'h1A3, 11'h1A4}) begin
      n_fail++; $display("FAIL stall_data: got %h/%h/%h/%h want 1A1/1A2/1A3/1A4", T_alta, T_media, Humo, Elec);
    end
    step(11'h3FF, 0, 0, 0); fd_count += int'(frame_done);
    n_tests++;
    if (fd_count !== 1) begin n_fail++; $display("FAIL stall_fd_count: got %0d want 1", fd_count); end
  endtask

  task automatic test_reset_midframe();
    step(11'h0B1, 1, 1, 0);
    step(11'h0B2, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== 44'h0 || locked !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h/%h/%h/%h l=%b v=%b want 0", T_alta, T_media, Humo, Elec, locked, valid);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    step(11'h0C1, 1, 1, 0);
    step(11'h0C2, 0, 1, 0);
    step(11'h0C3, 0, 1, 0);
    step(11'h0C4, 0, 1, 0);
    n_tests++;
    if ({T_alta, T_media, Humo, Elec} !== {11'h0C1, 11'h0C2, 11'h0C3, 11'h0C4} || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_frame: got %h/%h/%h/%h fd=%b want 0C1/0C2/0C3/0C4 fd=1", T_alta, T_media, Humo, Elec, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_ignore_prefix();
    test_early_sync();
    test_sync_loss();
    test_muestra_stall();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_captura.md
Name: demux_captura

Overview:
- Receive-side counterpart of the four-slot time-multiplexed sensor bus (T_alta, T_media, Humo, Elec, one 11-bit word per clock).
- Tracks frame alignment from a start-of-frame marker and de-serialises each slot into shadow registers.
- Publishes all four words atomically once per complete frame.
- Sits in front of the fire-control decision logic and flags any loss of frame alignment.

Parameters:
- WIDTH, 11, data word width of the bus and of each output.
- SLOTS, 4, slots per frame; fixed at 4 in this revision, slot index is 2 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- y_in  input  WIDTH  multiplexed bus word. Slot order: 0=T_alta, 1=T_media, 2=Humo, 3=Elec.
- sync  input  1  high when y_in carries slot 0; qualified by muestra.
- muestra  input  1  sample enable; tie high when the bus advances every clk.
- err_clr  input  1  clears sticky sync_err.
- T_alta  output  WIDTH  last complete-frame slot 0.
- T_media  output  WIDTH  last complete-frame slot 1.
- Humo  output  WIDTH  last complete-frame slot 2.
- Elec  output  WIDTH  last complete-frame slot 3.
- frame_done  output  1  one-cycle pulse, outputs just updated.
- valid  output  1  at least one complete frame captured since reset/resync.
- locked  output  1  FSM in LOCKED.
- sync_err  output  1  sticky alignment error.

Behaviour:
- Reset (async, high):
  - All data outputs, all shadow registers, frame_done, valid, locked and sync_err go to 0.
  - Slot counter goes to 0; FSM goes to HUNT.
- When muestra=0, nothing changes: state, counter and shadows hold, sync is ignored, and frame_done is 0 that cycle.
- FSM state HUNT (locked=0), on each sample:
  - sync=0: word discarded, stay in HUNT.
  - sync=1: shadow[0]<=y_in, slot<=1, go to LOCKED.
- FSM state LOCKED (locked=1), on each sample:
  - slot 0, sync=1: shadow[0]<=y_in, slot<=1.
  - slot 0, sync=0: set sync_err, discard word, valid<=0, go to HUNT.
  - slot 1 or 2, sync=0: shadow[slot]<=y_in, slot<=slot+1.
  - slot 3, sync=0: at this edge, T_alta/T_media/Humo <= shadow[0..2], Elec <= y_in, frame_done<=1, valid<=1, slot<=0 (wrap).
  - slot 1..3, sync=1 (early sync): set sync_err, drop the partial frame (outputs keep their previous values, no frame_done), shadow[0]<=y_in, slot<=1, stay in LOCKED.
- Latency: a word sampled in slot 3 is visible on the outputs in the cycle after that edge. Slot 0 data reaches the outputs 3 sampled cycles after capture.
- frame_done is high for exactly one clk after each output update; it never stays high across two cycles, even at back-to-back frames.
- Outputs change only at frame completion, never mid-frame.
- sync_err is sticky; err_clr=1 clears it on the next edge. If a new error occurs in the same cycle as err_clr, the set wins.
- Reset mid-frame: the partial frame is lost, outputs go to 0, and the block hunts again.

Decomposition:
- Shared package/include: WIDTH, slot index constants (SLOT_T_ALTA=0, SLOT_T_MEDIA=1, SLOT_HUMO=2, SLOT_ELEC=3), FSM state encoding (HUNT=0, LOCKED=1).
- Optional sub-module slot_tracker: the 2-bit slot counter, sync checking and HUNT/LOCKED FSM, producing slot, capture, commit and error strobes.
- demux_captura top: shadow/output registers plus flag logic.

Test Plan:
- Reset, then muestra=1 with frames {sync, 0x101, 0x202, 0x303, 0x404} repeated → locked=1 one cycle after the first sync. After slot 3: T_alta=0x101, T_media=0x202, Humo=0x303, Elec=0x404, frame_done for 1 cycle, valid=1.
- Words 0x7FF ×3 with sync=0 before the first sync → those words are ignored, outputs stay 0, locked=0. The first frame after sync publishes correctly.
- Locked, second frame 0x011/0x022 then sync asserted at slot 2 with 0x033 → sync_err=1, no frame_done, outputs keep the previous frame. The next frame starting at 0x033 completes and publishes 0x033 as T_alta.
- Locked, sync=0 at slot 0 → sync_err=1, valid=0, locked=0. With err_clr pulsed alone, sync_err clears next cycle. With err_clr coincident with a new error, sync_err stays 1.
- muestra toggled 1,0,1,0 across a frame → capture stalls during the 0 cycles. Outputs publish the same four values as with continuous muestra, and frame_done occurs once.
- Async reset asserted mid-frame (slot 2) between clock edges → all outputs 0 immediately, locked=0. The first frame after release publishes fresh values only.
